// File: rtl/store_trace_buffer_pkg.sv
// Shared defaults and width helpers for the store trace buffer.
package store_trace_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH  = 8;
  localparam int DROP_W     = 16;

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_trace_buffer_if.sv
// Store capture bus: core store strobe and flush in, trace head and status out.
interface store_trace_buffer_if
  import store_trace_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) ();

  localparam int CNT_W = cnt_width(DEPTH);

  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output we, address, write_data, flush, out_ready,
    input  out_valid, out_addr, out_data, count, overflow, drop_count
  );

  modport slave (
    input  we, address, write_data, flush, out_ready,
    output out_valid, out_addr, out_data, count, overflow, drop_count
  );

endinterface

// File: rtl/store_trace_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count; flush wins over push/pop.
// Head word is read combinationally from storage, so a push is visible one cycle later.
module sync_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/store_trace_buffer.sv
// Captures core stores inside an address window into a FIFO for a trace consumer,
// counting stores lost to a full buffer.
module store_trace_buffer
  import store_trace_pkg::*;
#(
  parameter int              DATA_W = DEF_DATA_W,
  parameter int              ADDR_W = DEF_ADDR_W,
  parameter int              DEPTH  = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] WIN_LO = '0,
  parameter logic [ADDR_W-1:0] WIN_HI = '1
) (
  input  logic clk,
  input  logic rst,
  store_trace_buffer_if.slave bus
);

  localparam int WORD_W = ADDR_W + DATA_W;

  logic [ADDR_W:0]   lo_diff;
  logic [ADDR_W:0]   hi_diff;
  logic              in_window;
  logic              eligible;
  logic              pop;
  logic              push;
  logic              drop;
  logic              full;
  logic              empty;
  logic [WORD_W-1:0] head_word;

  // Borrow-out of an extended subtraction gives the unsigned compare without
  // tripping constant-compare warnings when a window edge is 0 or all-ones.
  assign lo_diff   = {1'b0, bus.address} - {1'b0, WIN_LO};
  assign hi_diff   = {1'b0, WIN_HI} - {1'b0, bus.address};
  assign in_window = !lo_diff[ADDR_W] && !hi_diff[ADDR_W];
  assign eligible  = bus.we && in_window;

  assign pop  = bus.out_valid && bus.out_ready;
  assign push = eligible && (!full || pop);
  assign drop = eligible && full && !pop;

  sync_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .wdata ({bus.address, bus.write_data}),
    .rdata (head_word),
    .count (bus.count),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = !empty;
  assign bus.out_addr  = head_word[DATA_W +: ADDR_W];
  assign bus.out_data  = head_word[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.overflow   <= 1'b0;
      bus.drop_count <= '0;
    end else if (bus.flush) begin
      bus.overflow   <= 1'b0;
      bus.drop_count <= '0;
    end else if (drop) begin
      bus.overflow <= 1'b1;
      if (bus.drop_count != '1) bus.drop_count <= bus.drop_count + 1'b1;
    end
  end

endmodule
